multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/multicycle_ctrl.sv | 169 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle for multicycle_ctrl.
// master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if #(
   parameter int RADDR_W = 4
);
   logic [31:0]        instr;
   logic [3:0]         alu_flags;
   logic               mem_ack;
   logic               mem_req;
   logic               mem_we;
   logic               addr_src;
   logic               ir_we;
   logic               pc_we;
   logic [1:0]         pc_src;
   logic               reg_we;
   logic [RADDR_W-1:0] reg_waddr;
   logic [1:0]         alu_src_b;
   logic [1:0]         result_src;
   logic [3:0]         flags;
   logic               abort;
   logic [2:0]         state;

   modport master (
      input  instr, alu_flags, mem_ack,
      output mem_req, mem_we, addr_src, ir_we, pc_we, pc_src, reg_we, reg_waddr,
             alu_src_b, result_src, flags, abort, state
   );

   modport slave (
      output instr, alu_flags, mem_ack,
      input  mem_req, mem_we, addr_src, ir_we, pc_we, pc_src, reg_we, reg_waddr,
             alu_src_b, result_src, flags, abort, state
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset control FSM with memory-wait timeout and abort pulse.
// Optional CTRL_COND_EXEC_EN: evaluate the cond field against stored flags in DECODE.
module multicycle_ctrl #(
   parameter int RADDR_W = 4,
   parameter int TMO_CYC = 15
) (
   input  logic             clk,
   input  logic             rst,
   multicycle_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      FETCH    = 3'd0,
      DECODE   = 3'd1,
      EXEC_DP  = 3'd2,
      MEM_ADDR = 3'd3,
      MEM_RD   = 3'd4,
      MEM_WR   = 3'd5,
      WB       = 3'd6,
      BRANCH   = 3'd7
   } state_t;

   state_t     r_state, w_next;
   logic [3:0] r_flags;
   logic [7:0] r_wait;
   logic       r_abort;
   logic       r_from_rd;

   logic [3:0] w_cmd, w_rd;
   logic [1:0] w_op;
   logic       w_i, w_s, w_l, w_cond_ok, w_mem_phase, w_wait, w_tmo;

   assign w_cmd = bus.instr[24:21];
   assign w_rd  = bus.instr[15:12];
   assign w_op  = bus.instr[27:26];
   assign w_i   = bus.instr[25];
   assign w_l   = bus.instr[24];
   assign w_s   = bus.instr[20];

`ifdef CTRL_COND_EXEC_EN
   logic w_n, w_z, w_c, w_v;
   assign {w_n, w_z, w_c, w_v} = r_flags;
   always_comb begin
      case (bus.instr[31:28])
         4'h0:    w_cond_ok = w_z;
         4'h1:    w_cond_ok = !w_z;
         4'h2:    w_cond_ok = w_c;
         4'h3:    w_cond_ok = !w_c;
         4'h4:    w_cond_ok = w_n;
         4'h5:    w_cond_ok = !w_n;
         4'h6:    w_cond_ok = w_v;
         4'h7:    w_cond_ok = !w_v;
         4'h8:    w_cond_ok = w_c && !w_z;
         4'h9:    w_cond_ok = !w_c || w_z;
         4'hA:    w_cond_ok = (w_n == w_v);
         4'hB:    w_cond_ok = (w_n != w_v);
         4'hC:    w_cond_ok = !w_z && (w_n == w_v);
         4'hD:    w_cond_ok = w_z || (w_n != w_v);
         4'hE:    w_cond_ok = 1'b1;
         default: w_cond_ok = 1'b0;
      endcase
   end
`else
   assign w_cond_ok = 1'b1;
`endif

   // Only the memory-facing states listen to mem_ack; elsewhere it is ignored.
   assign w_mem_phase = (r_state == FETCH) || (r_state == MEM_RD) || (r_state == MEM_WR);
   assign w_wait      = w_mem_phase && !bus.mem_ack;
   assign w_tmo       = w_wait && (r_wait == 8'(TMO_CYC - 1));

   always_comb begin
      w_next         = r_state;
      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.addr_src   = 1'b0;
      bus.ir_we      = 1'b0;
      bus.pc_we      = 1'b0;
      bus.pc_src     = 2'b00;
      bus.reg_we     = 1'b0;
      bus.reg_waddr  = '0;
      bus.alu_src_b  = 2'b00;
      bus.result_src = 2'b00;
      case (r_state)
         FETCH: begin
            bus.mem_req = 1'b1;
            if (bus.mem_ack) begin
               bus.ir_we = 1'b1;
               bus.pc_we = 1'b1;
               w_next    = DECODE;
            end
         end
         DECODE: begin
            if (!w_cond_ok) w_next = FETCH;
            else begin
               case (w_op)
                  2'b00:   w_next = EXEC_DP;
                  2'b01:   w_next = MEM_ADDR;
                  2'b10:   w_next = BRANCH;
                  default: w_next = FETCH;
               endcase
            end
         end
         EXEC_DP: begin
            bus.alu_src_b = w_i ? 2'b01 : ((w_cmd == 4'b1101) ? 2'b10 : 2'b00);
            // TST/TEQ/CMP/CMN only set flags
            w_next = (w_cmd[3:2] == 2'b10) ? FETCH : WB;
         end
         MEM_ADDR: begin
            bus.alu_src_b = w_i ? 2'b00 : 2'b01;
            w_next        = w_s ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            bus.mem_req  = 1'b1;
            bus.addr_src = 1'b1;
            if (bus.mem_ack) w_next = WB;
         end
         MEM_WR: begin
            bus.mem_req  = 1'b1;
            bus.addr_src = 1'b1;
            bus.mem_we   = 1'b1;
            if (bus.mem_ack) w_next = FETCH;
         end
         WB: begin
            bus.result_src = r_from_rd ? 2'b01 : ((w_cmd == 4'b1101) ? 2'b10 : 2'b00);
            if (w_rd == 4'hF) begin
               bus.pc_we  = 1'b1;
               bus.pc_src = 2'b10;
            end else begin
               bus.reg_we    = 1'b1;
               bus.reg_waddr = RADDR_W'(w_rd);
            end
            w_next = FETCH;
         end
         BRANCH: begin
            bus.pc_we  = 1'b1;
            bus.pc_src = 2'b01;
            if (w_l) begin
               bus.reg_we     = 1'b1;
               bus.reg_waddr  = RADDR_W'(4'd14);
               bus.result_src = 2'b11;
            end
            w_next = FETCH;
         end
      endcase
      if (w_tmo) w_next = FETCH;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= FETCH;
         r_flags   <= 4'b0000;
         r_wait    <= 8'd0;
         r_abort   <= 1'b0;
         r_from_rd <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_abort   <= w_tmo;
         r_from_rd <= (r_state == MEM_RD);
         if (r_state == EXEC_DP && w_s) r_flags <= bus.alu_flags;
         // timeout already fired, an ack arrived, or the state moved: start over
         if (w_tmo || !w_wait || (w_next != r_state)) r_wait <= 8'd0;
         else                                         r_wait <= r_wait + 8'd1;
      end
   end

   assign bus.state = r_state;
   assign bus.flags = r_flags;
   assign bus.abort = r_abort;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed ARM sequences plus random instructions and
// random mem_ack rates, checked every cycle against an instruction-level phase-plan model.
module tb_multicycle_ctrl;
   localparam int TMO = 15;

   typedef struct packed {
      logic       mem_req, mem_we, addr_src, ir_we, pc_we;
      logic [1:0] pc_src;
      logic       reg_we;
      logic [3:0] waddr;
      logic [1:0] alu_src_b, result_src;
   } outs_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   multicycle_ctrl_if #(.RADDR_W(4)) bus();
   multicycle_ctrl #(.RADDR_W(4), .TMO_CYC(TMO)) dut (.clk(clk), .rst(rst), .bus(bus.master));

   int n_chk = 0;
   int n_pass = 0;

   // Model: queue of upcoming phases for the current instruction; empty means FETCH.
   // Phase 14 is the write-back that follows a load (shows as state 6).
   int          plan[$];
   logic [3:0]  m_flags;
   int          m_waits;
   logic        m_abort;
   logic [31:0] next_instr;

   int    tr_state[$];
   outs_t tr_o[$];
   logic  tr_abort[$];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   function automatic outs_t dut_outs();
      outs_t o;
      o = {bus.mem_req, bus.mem_we, bus.addr_src, bus.ir_we, bus.pc_we, bus.pc_src,
           bus.reg_we, bus.reg_waddr, bus.alu_src_b, bus.result_src};
      return o;
   endfunction

   function automatic int cur_phase();
      return (plan.size() != 0) ? plan[0] : 0;
   endfunction

`ifdef CTRL_COND_EXEC_EN
   function automatic logic cond_ok(logic [3:0] c, logic [3:0] f);
      logic n, z, cc, v;
      {n, z, cc, v} = f;
      case (c)
         4'h0: return z;           4'h1: return !z;
         4'h2: return cc;          4'h3: return !cc;
         4'h4: return n;           4'h5: return !n;
         4'h6: return v;           4'h7: return !v;
         4'h8: return cc && !z;    4'h9: return !cc || z;
         4'hA: return n == v;      4'hB: return n != v;
         4'hC: return !z && n == v;
         4'hD: return z || n != v;
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction
`endif

   // Phases an instruction walks through after a successful fetch.
   function automatic void plan_instr(logic [31:0] ins);
      int cmd;
      cmd = int'(ins[24:21]);
      plan.delete();
      plan.push_back(1);
`ifdef CTRL_COND_EXEC_EN
      if (!cond_ok(ins[31:28], m_flags)) return;
`endif
      case (ins[27:26])
         2'b00: begin
            plan.push_back(2);
            if (!(cmd >= 8 && cmd <= 11)) plan.push_back(6);
         end
         2'b01: begin
            plan.push_back(3);
            if (ins[20]) begin plan.push_back(4); plan.push_back(14); end
            else plan.push_back(5);
         end
         2'b10: plan.push_back(7);
         default: ;
      endcase
   endfunction

   function automatic outs_t expect_outs(int p, logic [31:0] ins, logic ack);
      outs_t o;
      logic [3:0] cmd;
      o = '0;
      cmd = ins[24:21];
      case (p)
         0: begin
            o.mem_req = 1'b1;
            if (ack) begin o.ir_we = 1'b1; o.pc_we = 1'b1; end
         end
         2: o.alu_src_b = ins[25] ? 2'd1 : ((cmd == 4'd13) ? 2'd2 : 2'd0);
         3: o.alu_src_b = ins[25] ? 2'd0 : 2'd1;
         4: begin o.mem_req = 1'b1; o.addr_src = 1'b1; end
         5: begin o.mem_req = 1'b1; o.addr_src = 1'b1; o.mem_we = 1'b1; end
         6, 14: begin
            o.result_src = (p == 14) ? 2'd1 : ((cmd == 4'd13) ? 2'd2 : 2'd0);
            if (ins[15:12] == 4'd15) begin o.pc_we = 1'b1; o.pc_src = 2'd2; end
            else begin o.reg_we = 1'b1; o.waddr = ins[15:12]; end
         end
         7: begin
            o.pc_we = 1'b1; o.pc_src = 2'd1;
            if (ins[24]) begin o.reg_we = 1'b1; o.waddr = 4'd14; o.result_src = 2'd3; end
         end
         default: ;
      endcase
      return o;
   endfunction

   // One clock: drive at negedge, compare, then advance the model across the posedge.
   task automatic step(logic ack, logic [3:0] af);
      int   p;
      logic fetched;
      fetched = 1'b0;
      @(negedge clk);
      bus.mem_ack   = ack;
      bus.alu_flags = af;
      #1;
      p = cur_phase();
      chk("state", 32'(bus.state), (p == 14) ? 32'd6 : 32'(p));
      chk("outs", 32'(dut_outs()), 32'(expect_outs(p, bus.instr, ack)));
      chk("flags", 32'(bus.flags), 32'(m_flags));
      chk("abort", 32'(bus.abort), 32'(m_abort));
      tr_state.push_back(int'(bus.state));
      tr_o.push_back(dut_outs());
      tr_abort.push_back(bus.abort);
      @(posedge clk);
      m_abort = 1'b0;
      if (p == 0 || p == 4 || p == 5) begin
         if (ack) begin
            m_waits = 0;
            if (p == 0) begin plan_instr(next_instr); fetched = 1'b1; end
            else void'(plan.pop_front());
         end else if (m_waits + 1 == TMO) begin
            m_waits = 0;
            plan.delete();
            m_abort = 1'b1;
         end else m_waits++;
      end else begin
         if (p == 2 && bus.instr[20]) m_flags = af;
         void'(plan.pop_front());
         m_waits = 0;
      end
      #1;
      if (fetched) bus.instr = next_instr;
   endtask

   task automatic clr();
      tr_state.delete();
      tr_o.delete();
      tr_abort.delete();
   endtask

   function automatic logic [31:0] seq(int n);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < n; i++) r = (r << 4) | 32'(tr_state[i]);
      return r;
   endfunction

   initial begin
      int probs[4];
      int pr;
      int cnt;
      probs = '{0, 20, 50, 100};
      rst = 1'b1;
      bus.instr = '0; bus.mem_ack = 1'b0; bus.alu_flags = '0;
      m_flags = '0; m_waits = 0; m_abort = 1'b0; next_instr = '0;
      #12;
      chk("reset_state", 32'(bus.state), 32'd0);
      chk("reset_flags", 32'(bus.flags), 32'd0);
      chk("reset_abort", 32'(bus.abort), 32'd0);
      chk("reset_mem_req", 32'(bus.mem_req), 32'd1);
      @(posedge clk); #1; rst = 1'b0;

      // ADD R1,R2,#5
      clr(); next_instr = 32'hE2821005;
      step(1'b1, 4'h0); repeat (4) step(1'b0, 4'h0);
      chk("add_states", seq(5), 32'h01260);
      chk("add_wb_regwe", 32'(tr_o[3].reg_we), 32'd1);
      chk("add_wb_waddr", 32'(tr_o[3].waddr), 32'd1);

      // LDR R3,[R4,#8], three wait cycles in MEM_RD
      clr(); next_instr = 32'hE5943008;
      step(1'b1, 4'h0); repeat (5) step(1'b0, 4'h0); step(1'b1, 4'h0); step(1'b0, 4'h0);
      chk("ldr_states", seq(8), 32'h01344446);
      chk("ldr_wb_rsrc", 32'(tr_o[7].result_src), 32'd1);
      chk("ldr_wb_waddr", 32'(tr_o[7].waddr), 32'd3);

      // CMPS latching Z, then BEQ taken
      clr(); next_instr = 32'hE3500000;
      step(1'b1, 4'h0); step(1'b0, 4'h0); step(1'b0, 4'b0100); step(1'b0, 4'h0);
      chk("cmp_states", seq(4), 32'h0120);
      chk("cmp_flags", 32'(bus.flags), 32'h4);
      clr(); next_instr = 32'h0A000002;
      step(1'b1, 4'h0); repeat (3) step(1'b0, 4'h0);
      chk("beq_states", seq(4), 32'h0170);
      chk("beq_pc_src", 32'(tr_o[2].pc_src), 32'd1);
      chk("beq_pc_we", 32'(tr_o[2].pc_we), 32'd1);

      // CMPS clearing flags, then BEQ again
      clr(); next_instr = 32'hE3500000;
      step(1'b1, 4'h0); repeat (3) step(1'b0, 4'h0);
      chk("cmp0_flags", 32'(bus.flags), 32'h0);
      clr(); next_instr = 32'h0A000002;
      step(1'b1, 4'h0); repeat (2) step(1'b0, 4'h0);
`ifdef CTRL_COND_EXEC_EN
      chk("beq_nt_states", seq(3), 32'h010);
`else
      chk("beq_nt_states", seq(3), 32'h017);
`endif

      // BL
      clr(); next_instr = 32'hEB000010;
      step(1'b1, 4'h0); repeat (3) step(1'b0, 4'h0);
      chk("bl_states", seq(3), 32'h017);
      chk("bl_ctrl", {28'd0, tr_o[2].pc_we, tr_o[2].reg_we, tr_o[2].result_src}, 32'hF);
      chk("bl_waddr", 32'(tr_o[2].waddr), 32'd14);

      // STR with no ack: timeout
      clr(); next_instr = 32'hE5843008;
      step(1'b1, 4'h0); repeat (19) step(1'b0, 4'h0);
      chk("str_last_wait_state", 32'(tr_state[17]), 32'd5);
      chk("str_last_wait_abort", 32'(tr_abort[17]), 32'd0);
      chk("str_tmo_state", 32'(tr_state[18]), 32'd0);
      chk("str_tmo_abort", 32'(tr_abort[18]), 32'd1);
      chk("str_tmo_we", {29'd0, tr_o[18].ir_we, tr_o[18].pc_we, tr_o[18].reg_we}, 32'd0);
      chk("str_abort_pulse", 32'(tr_abort[19]), 32'd0);

      // STR acked in the last allowed wait cycle: no abort
      clr(); next_instr = 32'hE5843008;
      step(1'b1, 4'h0); repeat (16) step(1'b0, 4'h0); step(1'b1, 4'h0); step(1'b0, 4'h0);
      chk("str_late_ack_state", 32'(tr_state[18]), 32'd0);
      chk("str_late_ack_abort", 32'(tr_abort[18]), 32'd0);

      // Reset between edges during MEM_RD
      clr(); next_instr = 32'hE3500000;
      step(1'b1, 4'h0); step(1'b0, 4'h0); step(1'b0, 4'hF); step(1'b0, 4'h0);
      chk("pre_rst_flags", 32'(bus.flags), 32'hF);
      next_instr = 32'hE5943008;
      step(1'b1, 4'h0); repeat (4) step(1'b0, 4'h0);
      #2; rst = 1'b1; #1;
      chk("rst_async_state", 32'(bus.state), 32'd0);
      chk("rst_async_flags", 32'(bus.flags), 32'd0);
      chk("rst_async_abort", 32'(bus.abort), 32'd0);
      plan.delete(); m_flags = '0; m_waits = 0; m_abort = 1'b0;
      @(posedge clk); #1; rst = 1'b0;
      clr();
      step(1'b0, 4'h0); step(1'b1, 4'h0); step(1'b0, 4'h0);
      chk("rst_release_fetch", {28'd0, 1'b0, 3'(tr_state[0])}, 32'd0);
      chk("rst_release_req", 32'(tr_o[0].mem_req), 32'd1);
      cnt = 0;
      foreach (tr_o[i]) if (tr_o[i].reg_we) cnt++;
      chk("rst_no_regwe", 32'(cnt), 32'd0);

      // Random instructions with varying memory ack rates
      for (int ep = 0; ep < 50; ep++) begin
         pr = probs[$urandom_range(0, 3)];
         for (int c = 0; c < 60; c++) begin
            next_instr = $urandom();
            step(($urandom_range(0, 99) < pr), 4'($urandom_range(0, 15)));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
